uart_tx_serializer: RTL and testbench

- Downstream consumer of the UART TXDATA register write path.
- Buffers bytes written by the CPU-side peripheral in a small FIFO and shifts them out on a physical 8N1 serial line at a fixed baud rate.
- The TXDATA write strobe drives tx_valid.
- tx_ready feeds the status register's ready bit, replacing the simulation-only print path on hardware targets.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_serializer.sv | 127 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state type, frame width
// and serial line levels used by the TX (and later RX) path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports: clk, rst (sync, high), push/wdata, pop/rdata, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Writes into a full FIFO are silently dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffered 8N1 UART transmitter: FIFO of bytes shifted out LSB first.
// Ports: clk, rst, tx_data/tx_valid/tx_ready, txd, busy, fifo_count.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] fifo_count
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);

    uart_tx_state_t      state;
    logic [BW-1:0]       baud;
    logic [IW-1:0]       bitidx;
    logic [7:0]          shift;
    logic [7:0]          head;
    logic                full;
    logic                empty;
    logic                term;
    logic                last_bit;
    logic                pop;

    assign term     = (baud == BW'(CLKS_PER_BIT - 1));
    assign last_bit = (bitidx == IW'(UART_DATA_BITS - 1));

    // Pops happen only when a new frame is launched: from idle, or
    // straight out of a finished stop bit (no inter-frame gap).
    assign pop = !empty &&
                 ((state == IDLE) || ((state == STOP) && term));

    assign tx_ready = !full;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CW    (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            txd    <= UART_IDLE;
            baud   <= '0;
            bitidx <= '0;
            shift  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    txd  <= UART_IDLE;
                    baud <= '0;
                    if (!empty) begin
                        shift <= head;
                        txd   <= UART_START;
                        state <= START;
                    end
                end
                START: begin
                    if (term) begin
                        baud   <= '0;
                        bitidx <= '0;
                        txd    <= shift[0];
                        state  <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (term) begin
                        baud <= '0;
                        if (last_bit) begin
                            txd   <= UART_IDLE;
                            state <= STOP;
                        end else begin
                            // Next bit is shift[1] before the shift lands.
                            shift  <= {1'b0, shift[7:1]};
                            txd    <= shift[1];
                            bitidx <= bitidx + IW'(1);
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (term) begin
                        baud <= '0;
                        if (!empty) begin
                            shift <= head;
                            txd   <= UART_START;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    txd   <= UART_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer against a
// frame-timing reference model (byte queue + frame start times).
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FRAME = 10 * CPB;

    logic          clk;
    logic          rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int n_cmp;
    int n_bad;

    // Reference model: queued bytes, index of the last clock edge,
    // the edge at which the current frame started (-1 when idle).
    logic [7:0] mq[$];
    int         cyc;
    int         fstart;
    logic [7:0] fbyte;

    logic [CW+2:0] obs;
    logic [CW+2:0] exp;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_txd();
        int k;
        if (fstart < 0) return 1'b1;
        k = (cyc - fstart) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return fbyte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [CW+2:0] m_exp();
        logic b;
        b = (fstart >= 0) || (mq.size() != 0);
        return {m_txd(), b, logic'(mq.size() < DEPTH), CW'(mq.size())};
    endfunction

    // Advance one edge; update the model from the inputs seen at it.
    task automatic tick();
        logic       v;
        logic [7:0] d;
        logic       r;
        bit         was_full;
        @(posedge clk);
        v = tx_valid;
        d = tx_data;
        r = rst;
        cyc++;
        if (r) begin
            mq.delete();
            fstart = -1;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (fstart >= 0 && cyc - fstart >= FRAME) fstart = -1;
            if (fstart < 0 && mq.size() > 0) begin
                fbyte  = mq.pop_front();
                fstart = cyc;
            end
            if (v && !was_full) mq.push_back(d);
        end
        #1;
        obs = {txd, busy, tx_ready, fifo_count};
        exp = m_exp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b1, CW'(0)}) begin
            n_bad++;
            $display("FAIL reset_state got=%b exp=%b", obs,
                     {1'b1, 1'b0, 1'b1, CW'(0)});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_single_byte();
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick();
        tx_valid = 1'b0;
        tx_data  = $urandom;
        n_cmp++;
        if (fifo_count !== CW'(1) || txd !== 1'b1) begin
            n_bad++;
            $display("FAIL single_e0 got=%b/%0d exp=1/1", txd, fifo_count);
        end
        tick();
        n_cmp++;
        if (txd !== 1'b0 || fifo_count !== CW'(0)) begin
            n_bad++;
            $display("FAIL single_e1 got=%b/%0d exp=0/0", txd, fifo_count);
        end
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL single_line cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
            if (i == FRAME - 2 || i == FRAME - 1) begin
                n_cmp++;
                if (busy !== (i == FRAME - 2)) begin
                    n_bad++;
                    $display("FAIL single_busy i=%0d got=%b exp=%b",
                             i, busy, (i == FRAME - 2));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int low_seen;
        low_seen = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tick();
        tx_data = 8'h0F;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b_line cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
            if (i < 2 * FRAME && busy) low_seen++;
            tick();
        end
        n_cmp++;
        if (low_seen != 2 * FRAME) begin
            n_bad++;
            $display("FAIL b2b_busy_cycles got=%0d exp=%0d",
                     low_seen, 2 * FRAME);
        end
    endtask

    task automatic test_overflow();
        bit saw_not_ready;
        saw_not_ready = 0;
        for (int i = 0; i < 12; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'(i);
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL ovf_fill cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
            if (!tx_ready) saw_not_ready = 1;
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== CW'(8) || !saw_not_ready) begin
            n_bad++;
            $display("FAIL ovf_full got=%0d/%b exp=8/1",
                     fifo_count, saw_not_ready);
        end
        for (int i = 0; i < 10 * FRAME; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL ovf_line cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_drain got=%b exp=0", busy);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== CW'(3)) begin
            n_bad++;
            $display("FAIL simul_setup got=%0d exp=3", fifo_count);
        end
        for (int i = 0; i < FRAME && (cyc + 1 - fstart) != FRAME; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL simul_wait cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== CW'(3) || txd !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_pushpop got=%0d/%b exp=3/0",
                     fifo_count, txd);
        end
        for (int i = 0; i < 4 * FRAME + 4; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL simul_line cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 5) == 0);
            tx_data  = 8'($urandom);
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rand_line cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
        tx_valid = 1'b0;
        for (int i = 0; i < (DEPTH + 2) * FRAME; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rand_drain cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_data = 8'h11;
        tick();
        tx_data = 8'h22;
        tick();
        tx_valid = 1'b0;
        // Wait for the middle of data bit 3 (frame offset 4*CPB + 1).
        for (int i = 0; i < FRAME && (cyc - fstart) != 4 * CPB + 1; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rmid_wait cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
        n_cmp++;
        if (txd !== 1'b1 || fifo_count !== CW'(2)) begin
            n_bad++;
            $display("FAIL rmid_pre got=%b/%0d exp=1/2", txd, fifo_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b1, CW'(0)}) begin
            n_bad++;
            $display("FAIL rmid_reset got=%b exp=%b", obs,
                     {1'b1, 1'b0, 1'b1, CW'(0)});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_cmp++;
            if (txd !== 1'b1 || busy !== 1'b0 || obs !== exp) begin
                n_bad++;
                $display("FAIL rmid_quiet cyc=%0d got=%b exp=%b",
                         cyc, obs, exp);
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        fstart   = -1;
        fbyte    = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
